alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the 16-bit registered ALU (A, B, ALU_FUN in; ALU_OUT and flags out).

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_regfile.sv | 35 +++
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU command sequencer
package alu_seq_pkg;

    // Sequencer phases: waiting for a command, waiting on the ALU, committing the result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_e;

    localparam int FUN_W  = 4;
    localparam int FLAG_W = 5;

    // ALU_FUN codes; the sequencer passes them through without interpreting them
    localparam logic [FUN_W-1:0] OP_ADD    = 4'd0;
    localparam logic [FUN_W-1:0] OP_SUB    = 4'd1;
    localparam logic [FUN_W-1:0] OP_MUL    = 4'd2;
    localparam logic [FUN_W-1:0] OP_DIV    = 4'd3;
    localparam logic [FUN_W-1:0] OP_AND    = 4'd4;
    localparam logic [FUN_W-1:0] OP_OR     = 4'd5;
    localparam logic [FUN_W-1:0] OP_NAND   = 4'd6;
    localparam logic [FUN_W-1:0] OP_NOR    = 4'd7;
    localparam logic [FUN_W-1:0] OP_XOR    = 4'd8;
    localparam logic [FUN_W-1:0] OP_XNOR   = 4'd9;
    localparam logic [FUN_W-1:0] OP_CMP_EQ = 4'd10;
    localparam logic [FUN_W-1:0] OP_CMP_GT = 4'd11;
    localparam logic [FUN_W-1:0] OP_CMP_LT = 4'd12;
    localparam logic [FUN_W-1:0] OP_SHR    = 4'd13;
    localparam logic [FUN_W-1:0] OP_SHL    = 4'd14;
    localparam logic [FUN_W-1:0] OP_NOP    = 4'd15;

    // Bit positions inside the {Carry, Arith, Logic, CMP, Shift} flag vector
    localparam int FLAG_CARRY = 4;
    localparam int FLAG_ARITH = 3;
    localparam int FLAG_LOGIC = 2;
    localparam int FLAG_CMP   = 1;
    localparam int FLAG_SHIFT = 0;

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - operand register file, two async reads and one sync write
module alu_seq_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Reads see the contents before any write on the same edge
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

    // Clear every entry on reset, otherwise commit the single write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - register-addressed command issue stage for a registered ALU
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FUN_W-1:0]  cmd_op,
    input  logic [AW-1:0]     cmd_src_a,
    input  logic [AW-1:0]     cmd_src_b,
    input  logic [AW-1:0]     cmd_dst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_err,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUN_W-1:0]  alu_fun,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [FLAG_W-1:0] rsp_flags
);

    // EXEC lasts ALU_LAT cycles; the counter runs 0 .. ALU_LAT-1
    localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

    seq_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AW-1:0]     dst_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [FUN_W-1:0]  alu_fun_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic [FLAG_W-1:0] rsp_flags_q;
    logic              rsp_valid_q;
    logic              wr_err_q;

    logic              accept;
    logic              wb_fire;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [WIDTH-1:0]  rf_wdata;
    logic [WIDTH-1:0]  rd_a, rd_b;

    alu_seq_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (cmd_src_a),
        .raddr_b_i (cmd_src_b),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

    // Next-state, handshake and regfile write-port mux; host loads and writeback never share a state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        wb_fire   = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = wr_addr;
        rf_wdata  = wr_data;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = ~rst;
                accept    = cmd_valid & ~rst;
                rf_we     = wr_en;
                if (accept) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                wb_fire  = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = dst_q;
                rf_wdata = alu_out;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture at acceptance, response capture at writeback, dropped-load flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_valid_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= wb_fire;
            wr_err_q    <= wr_en & (state_q != ST_IDLE);
            if (accept) begin
                alu_a_q   <= rd_a;
                alu_b_q   <= rd_b;
                alu_fun_q <= cmd_op;
                dst_q     <= cmd_dst;
            end
            if (wb_fire) begin
                rsp_data_q  <= alu_out;
                rsp_flags_q <= alu_flags;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a registered ALU
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_err;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;

    int          n_checks;
    int          n_pass;
    logic [15:0] mdl [8];

    alu_cmd_sequencer #(.WIDTH(16), .DEPTH(8), .ALU_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_dst   (cmd_dst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaviour of the 16-bit ALU: {flags, result}
    function automatic logic [20:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  f;
        s = {1'b0, a} + {1'b0, b};
        r = '0;
        f = '0;
        case (op)
            OP_ADD:    begin r = s[15:0]; f[FLAG_CARRY] = s[16]; f[FLAG_ARITH] = 1'b1; end
            OP_SUB:    begin r = a - b; f[FLAG_ARITH] = 1'b1; end
            OP_MUL:    begin r = a * b; f[FLAG_ARITH] = 1'b1; end
            OP_DIV:    begin r = (b == 16'd0) ? 16'd0 : a / b; f[FLAG_ARITH] = 1'b1; end
            OP_AND:    begin r = a & b; f[FLAG_LOGIC] = 1'b1; end
            OP_OR:     begin r = a | b; f[FLAG_LOGIC] = 1'b1; end
            OP_NAND:   begin r = ~(a & b); f[FLAG_LOGIC] = 1'b1; end
            OP_NOR:    begin r = ~(a | b); f[FLAG_LOGIC] = 1'b1; end
            OP_XOR:    begin r = a ^ b; f[FLAG_LOGIC] = 1'b1; end
            OP_XNOR:   begin r = ~(a ^ b); f[FLAG_LOGIC] = 1'b1; end
            OP_CMP_EQ: begin r = {15'd0, a == b}; f[FLAG_CMP] = 1'b1; end
            OP_CMP_GT: begin r = {15'd0, a > b}; f[FLAG_CMP] = 1'b1; end
            OP_CMP_LT: begin r = {15'd0, a < b}; f[FLAG_CMP] = 1'b1; end
            OP_SHR:    begin r = a >> 1; f[FLAG_SHIFT] = 1'b1; end
            OP_SHL:    begin r = a << 1; f[FLAG_SHIFT] = 1'b1; end
            default:   begin r = '0; end
        endcase
        return {f, r};
    endfunction

    // Registered ALU with one edge of latency
    always @(posedge clk) {alu_flags, alu_out} <= alu_calc(alu_fun, alu_a, alu_b);

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    // Host load in IDLE, one cycle
    task automatic host_load(input logic [2:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        mdl[addr] = data;
    endtask

    // Issue one command (optionally with a same-cycle host load) and wait for its response
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                           input logic ld, input logic [2:0] la, input logic [15:0] ldat,
                           output logic [15:0] data, output logic [4:0] flg, output int lat, output logic ok);
        int w;
        ok = 1'b0; lat = -1; data = '0; flg = '0; w = 0;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (!cmd_ready) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
        if (ld) begin wr_en = 1'b1; wr_addr = la; wr_data = ldat; end
        @(negedge clk);
        cmd_valid = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin lat = i; data = rsp_data; flg = rsp_flags; ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else n_pass++;
        n_checks++; if ({alu_a, alu_b, alu_fun} !== 36'd0) $display("FAIL reset_alu_ops: got %h want 0", {alu_a, alu_b, alu_fun}); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_data, rsp_flags, wr_err} !== 23'd0) $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_data, rsp_flags, wr_err}); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] d; logic [4:0] f; int lat; logic ok;
        host_load(3'd1, 16'd5);
        host_load(3'd2, 16'd7);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[3] = 16'h000C;
        n_checks++; if (ok !== 1'b1 || lat != 2) $display("FAIL add_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (d !== 16'h000C) $display("FAIL add_data: got %h want 000c", d); else n_pass++;
        n_checks++; if (f !== 5'b01000) $display("FAIL add_flags: got %b want 01000", f); else n_pass++;
        run_cmd(OP_SUB, 3'd3, 3'd1, 3'd4, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[4] = 16'h0007;
        n_checks++; if (ok !== 1'b1 || d !== 16'h0007) $display("FAIL sub_dep_data: got %h want 0007", d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [20:0] e; int nacc, npulse, last, since, viol;
        nacc = 0; npulse = 0; last = -1; since = 99; viol = 0;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src_a = 3'd5; cmd_src_b = 3'd1; cmd_dst = 3'd5;
        for (int c = 0; c < 14; c++) begin
            if (cmd_valid && cmd_ready) begin nacc++; since = 0; end
            @(negedge clk);
            since++;
            if (nacc == 3) cmd_valid = 1'b0;
            if ((since == 1 || since == 2) && cmd_ready !== 1'b0) viol++;
            if (rsp_valid) begin
                e = alu_calc(OP_ADD, mdl[5], mdl[1]);
                mdl[5] = e[15:0];
                n_checks++; if (rsp_data !== e[15:0]) $display("FAIL b2b_data%0d: got %h want %h", npulse, rsp_data, e[15:0]); else n_pass++;
                if (last >= 0) begin
                    n_checks++; if (c - last != 3) $display("FAIL b2b_spacing%0d: got %0d want 3", npulse, c - last); else n_pass++;
                end
                last = c;
                npulse++;
            end
        end
        cmd_valid = 1'b0;
        n_checks++; if (npulse != 3) $display("FAIL b2b_pulses: got %0d want 3", npulse); else n_pass++;
        n_checks++; if (nacc != 3) $display("FAIL b2b_accepts: got %0d want 3", nacc); else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL b2b_ready_busy: got %0d want 0 cycles ready while busy", viol); else n_pass++;
    endtask

    task automatic test_wr_drop();
        logic [20:0] e; logic [15:0] d; logic [4:0] f; int lat; logic ok;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL drop_pre_ready: got %b want 1", cmd_ready); else n_pass++;
        e = alu_calc(OP_ADD, mdl[1], mdl[2]); mdl[6] = e[15:0];
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd6;
        @(negedge clk);
        cmd_valid = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hDEAD;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (wr_err !== 1'b1) $display("FAIL drop_wr_err: got %b want 1", wr_err); else n_pass++;
        @(negedge clk);
        n_checks++; if (wr_err !== 1'b0) $display("FAIL drop_wr_err_pulse: got %b want 0", wr_err); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== e[15:0]) $display("FAIL drop_rsp: got %b/%h want 1/%h", rsp_valid, rsp_data, e[15:0]); else n_pass++;
        e = alu_calc(OP_ADD, mdl[1], mdl[2]);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd7, 1'b1, 3'd1, 16'd9, d, f, lat, ok);
        mdl[1] = 16'd9; mdl[7] = e[15:0];
        n_checks++; if (ok !== 1'b1 || d !== 16'h000C) $display("FAIL sameload_old_r1: got %h want 000c", d); else n_pass++;
        run_cmd(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[0] = 16'd18;
        n_checks++; if (ok !== 1'b1 || d !== 16'h0012) $display("FAIL sameload_commit: got %h want 0012", d); else n_pass++;
    endtask

    task automatic test_cmp_nop();
        logic [15:0] d; logic [4:0] f; int lat; logic ok;
        host_load(3'd1, 16'd5);
        run_cmd(OP_CMP_GT, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[3] = 16'd0;
        n_checks++; if (ok !== 1'b1 || d !== 16'h0000) $display("FAIL cmp_gt_data: got %h want 0000", d); else n_pass++;
        n_checks++; if (f[FLAG_CMP] !== 1'b1) $display("FAIL cmp_gt_flag: got %b want 1", f[FLAG_CMP]); else n_pass++;
        run_cmd(OP_CMP_LT, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[3] = 16'd1;
        n_checks++; if (ok !== 1'b1 || d !== 16'h0001) $display("FAIL cmp_lt_data: got %h want 0001", d); else n_pass++;
        run_cmd(OP_NOP, 3'd1, 3'd2, 3'd2, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[2] = 16'd0;
        n_checks++; if (ok !== 1'b1 || d !== 16'h0000) $display("FAIL nop_data: got %h want 0000", d); else n_pass++;
        run_cmd(OP_ADD, 3'd2, 3'd1, 3'd4, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        mdl[4] = 16'd5;
        n_checks++; if (ok !== 1'b1 || d !== 16'h0005) $display("FAIL nop_wrote_zero: got %h want 0005", d); else n_pass++;
    endtask

    task automatic test_random();
        logic [20:0] e; logic [15:0] d; logic [4:0] f; int lat; logic ok;
        logic [3:0] op; logic [2:0] a, b, dst, la; logic ld; logic [15:0] ldat;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(1, 0) == 1) host_load(3'($urandom_range(7, 0)), 16'($urandom));
            op = 4'($urandom_range(15, 0));
            a = 3'($urandom_range(7, 0)); b = 3'($urandom_range(7, 0)); dst = 3'($urandom_range(7, 0));
            ld = ($urandom_range(3, 0) == 0); la = 3'($urandom_range(7, 0)); ldat = 16'($urandom);
            e = alu_calc(op, mdl[a], mdl[b]);
            run_cmd(op, a, b, dst, ld, la, ldat, d, f, lat, ok);
            if (ld) mdl[la] = ldat;
            mdl[dst] = e[15:0];
            n_checks++; if (ok !== 1'b1 || lat != 2) $display("FAIL rand%0d_latency: got %0d want 2", it, lat); else n_pass++;
            n_checks++; if ({f, d} !== e) $display("FAIL rand%0d_op%0d: got %h want %h", it, op, {f, d}, e); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d; logic [4:0] f; int lat; logic ok; int pulses;
        host_load(3'd1, 16'd5);
        host_load(3'd2, 16'd7);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd3;
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL abort_ready_in_rst: got %b want 0", cmd_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if ({alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_flags, wr_err} !== 59'd0)
            $display("FAIL abort_outputs_zero: got %h want 0", {alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_flags, wr_err}); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        pulses = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid) pulses++; end
        n_checks++; if (pulses != 0) $display("FAIL abort_no_rsp: got %0d want 0", pulses); else n_pass++;
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'd0, d, f, lat, ok);
        n_checks++; if (ok !== 1'b1 || d !== 16'h0000) $display("FAIL abort_rf_cleared: got %h want 0000", d); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_wr_drop();
        test_cmp_nop();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
